// File: rtl/hex_uart_dumper.sv
// Buffers DATA_BYTES-wide words in a small FIFO and streams each one to a UART write port
// as ASCII hex digits (MSB nibble first), then a separator or a CR/LF line wrap.
module hex_uart_dumper #(
  parameter int          DATA_BYTES     = 1,
  parameter int          FIFO_W         = 2,
  parameter int          WORDS_PER_LINE = 8,
  parameter logic [7:0]  SEP_CHAR       = 8'h20,
  parameter bit          UPPER_CASE     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*DATA_BYTES-1:0] din,
  input  logic                    din_valid,
  output logic                    din_full,
  output logic                    overflow_tick,
  input  logic                    tx_full,
  output logic                    wr_uart,
  output logic [7:0]              w_data,
  output logic                    busy
);
  localparam int DW    = 8 * DATA_BYTES;
  localparam int NIB   = 2 * DATA_BYTES;
  localparam int NW    = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int DEPTH = 1 << FIFO_W;
  localparam int WC_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [FIFO_W:0] FULL_CNT = (FIFO_W+1)'(DEPTH);
  localparam logic [WC_W-1:0] LAST_W   = WC_W'((WORDS_PER_LINE == 0) ? 0 : WORDS_PER_LINE - 1);
  localparam logic [NW-1:0]   TOP_NIB  = NW'(NIB - 1);

  typedef enum logic [2:0] {IDLE, DIGIT, SEP, CR, LF} state_t;

  state_t              state;
  logic [DW-1:0]       mem [DEPTH];
  logic [FIFO_W-1:0]   wptr, rptr;
  logic [FIFO_W:0]     count, count_nxt;
  logic                ne_r;
  logic [DW-1:0]       data_reg;
  logic [NW-1:0]       nibble_cnt;
  logic [WC_W-1:0]     word_cnt;
  logic                push, pop, wrap_now;
  logic [DW-1:0]       shifted;
  logic [3:0]          nib;

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    if (n < 4'd10) return {4'h0, n} + 8'h30;
    else           return {4'h0, n} + (UPPER_CASE ? 8'h37 : 8'h57);
  endfunction

  // Full is checked against the pre-edge count, so a write is refused even if a pop frees a slot.
  assign push = din_valid && !din_full;
  // ne_r lags count by a cycle; safe because every pop leaves idle for at least three cycles.
  assign pop  = (state == IDLE) && ne_r && (count != '0);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + (FIFO_W+1)'(1);
    else if (pop && !push) count_nxt = count - (FIFO_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      ne_r          <= 1'b0;
      din_full      <= 1'b0;
      overflow_tick <= 1'b0;
    end else begin
      if (push) wptr <= wptr + FIFO_W'(1);
      if (pop)  rptr <= rptr + FIFO_W'(1);
      count         <= count_nxt;
      ne_r          <= (count != '0);
      din_full      <= (count_nxt == FULL_CNT);
      overflow_tick <= din_valid && din_full;
    end
  end

  assign wrap_now = (WORDS_PER_LINE != 0) && (word_cnt == LAST_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      data_reg   <= '0;
      nibble_cnt <= '0;
      word_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          data_reg   <= mem[rptr];
          nibble_cnt <= TOP_NIB;
          state      <= DIGIT;
        end
        DIGIT: if (!tx_full) begin
          if (nibble_cnt == '0) state <= SEP;
          else                  nibble_cnt <= nibble_cnt - NW'(1);
        end
        SEP: if (!tx_full) begin
          if (wrap_now) begin
            word_cnt <= '0;
            state    <= CR;
          end else begin
            word_cnt <= word_cnt + WC_W'(1);
            state    <= IDLE;
          end
        end
        CR: if (!tx_full) state <= LF;
        LF: if (!tx_full) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign shifted = data_reg >> {nibble_cnt, 2'b00};
  assign nib     = shifted[3:0];

  always_comb begin
    w_data  = SEP_CHAR;
    wr_uart = 1'b0;
    case (state)
      DIGIT: begin w_data = to_ascii(nib); wr_uart = !tx_full; end
      SEP:   wr_uart = !tx_full && !wrap_now;
      CR:    begin w_data = 8'h0D; wr_uart = !tx_full; end
      LF:    begin w_data = 8'h0A; wr_uart = !tx_full; end
      default: ;
    endcase
  end

  assign busy = (state != IDLE) || (count != '0);
endmodule

// File: tb/tb_hex_uart_dumper.sv
// Directed bench: three dumper configurations, chars captured on the falling edge.
module tb_hex_uart_dumper;
  typedef logic [7:0] bq_t[$];

  logic clk, reset, tx_full;
  logic [7:0]  din0, din2;
  logic [15:0] din1;
  logic dv0, dv1, dv2;
  logic full0, full1, full2, ovf0, ovf1, ovf2, wr0, wr1, wr2, busy0, busy1, busy2;
  logic [7:0] wd0, wd1, wd2;

  int   n_chk = 0, n_pass = 0, cyc = 0, viol = 0, ovf_cnt = 0, acc;
  bq_t  q0, q1, q2, e;
  int   cq0[$];

  hex_uart_dumper u0 (
    .clk(clk), .reset(reset), .din(din0), .din_valid(dv0), .din_full(full0),
    .overflow_tick(ovf0), .tx_full(tx_full), .wr_uart(wr0), .w_data(wd0), .busy(busy0));

  hex_uart_dumper #(.DATA_BYTES(2), .UPPER_CASE(1'b0)) u1 (
    .clk(clk), .reset(reset), .din(din1), .din_valid(dv1), .din_full(full1),
    .overflow_tick(ovf1), .tx_full(tx_full), .wr_uart(wr1), .w_data(wd1), .busy(busy1));

  hex_uart_dumper #(.WORDS_PER_LINE(2)) u2 (
    .clk(clk), .reset(reset), .din(din2), .din_valid(dv2), .din_full(full2),
    .overflow_tick(ovf2), .tx_full(tx_full), .wr_uart(wr2), .w_data(wd2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr0) begin q0.push_back(wd0); cq0.push_back(cyc); end
    if (wr1) q1.push_back(wd1);
    if (wr2) q2.push_back(wd2);
    if (tx_full && (wr0 || wr1 || wr2)) viol++;
    if (ovf0) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_seq(input string tag, input bq_t got, input bq_t exp);
    check({tag, " len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s c%0d", tag, i), (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF,
            {24'h0, exp[i]});
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Callers sit at #1 after a rising edge, so consecutive calls write on consecutive edges.
  task automatic put0(input logic [7:0] d);
    din0 = d; dv0 = 1'b1; tick(1); dv0 = 1'b0;
  endtask

  task automatic put2(input logic [7:0] d);
    din2 = d; dv2 = 1'b1; tick(1); dv2 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tx_full = 1'b0;
    dv0 = 0; dv1 = 0; dv2 = 0; din0 = '0; din1 = '0; din2 = '0;
    tick(2);
    check("rst din_full", full0, 1'b0);
    check("rst overflow", ovf0, 1'b0);
    check("rst wr_uart", wr0, 1'b0);
    check("rst busy", busy0, 1'b0);
    check("rst w_data", wd0, 8'h20);
    reset = 1'b0;
    tick(1);

    // 1: single byte, latency and back-to-back chars
    q0.delete(); cq0.delete();
    put0(8'hF0); acc = cyc;
    tick(10);
    e = '{8'h46, 8'h30, 8'h20};
    chk_seq("t1", q0, e);
    if (cq0.size() == 3) begin
      check("t1 latency", cq0[0] - acc, 2);
      check("t1 gap01", cq0[1] - cq0[0], 1);
      check("t1 gap12", cq0[2] - cq0[1], 1);
    end else check("t1 stamps", cq0.size(), 3);
    check("t1 busy", busy0, 1'b0);

    // 2: two-byte word, lower case
    din1 = 16'h1A2F; dv1 = 1'b1; tick(1); dv1 = 1'b0;
    tick(15);
    e = '{8'h31, 8'h61, 8'h32, 8'h66, 8'h20};
    chk_seq("t2", q1, e);

    // 3: line wrap every two words
    put2(8'h01); put2(8'h02); put2(8'h03);
    tick(30);
    e = '{8'h30, 8'h31, 8'h20, 8'h30, 8'h32, 8'h0D, 8'h0A, 8'h30, 8'h33, 8'h20};
    chk_seq("t3", q2, e);
    check("t3 busy", busy2, 1'b0);

    // 4: backpressure mid-word and before the separator
    q0.delete(); viol = 0;
    put0(8'hC5);
    tick(3);
    tx_full = 1'b1; tick(3); tx_full = 1'b0;
    tick(1);
    tx_full = 1'b1; tick(2); tx_full = 1'b0;
    tick(10);
    e = '{8'h43, 8'h35, 8'h20};
    chk_seq("t4", q0, e);
    check("t4 wr while full", viol, 0);

    // 5: fill FIFO under backpressure, sixth write overflows
    q0.delete(); viol = 0; ovf_cnt = 0;
    tx_full = 1'b1;
    put0(8'h10); put0(8'h11); put0(8'h12); put0(8'h13);
    check("t5 not full at 4", full0, 1'b0);
    put0(8'h14);
    check("t5 full at 5", full0, 1'b1);
    put0(8'h15);
    check("t5 ovf pulse", ovf0, 1'b1);
    tick(1);
    check("t5 ovf drop", ovf0, 1'b0);
    check("t5 ovf count", ovf_cnt, 1);
    check("t5 wr while full", viol, 0);
    tx_full = 1'b0;
    tick(40);
    e = '{8'h31, 8'h30, 8'h20, 8'h31, 8'h31, 8'h20, 8'h31, 8'h32, 8'h20,
          8'h31, 8'h33, 8'h20, 8'h31, 8'h34, 8'h20};
    chk_seq("t5", q0, e);
    check("t5 busy", busy0, 1'b0);
    check("t5 full after", full0, 1'b0);

    // 6: reset after the first digit with two words queued
    q0.delete();
    tx_full = 1'b1;
    put0(8'hAB); put0(8'h11); put0(8'h22);
    tx_full = 1'b0;
    tick(1);
    tx_full = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("t6 rst wr_uart", wr0, 1'b0);
    check("t6 rst busy", busy0, 1'b0);
    check("t6 rst din_full", full0, 1'b0);
    check("t6 rst w_data", wd0, 8'h20);
    tx_full = 1'b0;
    tick(2);
    reset = 1'b0;
    e = '{8'h41};
    chk_seq("t6 pre", q0, e);
    q0.delete();
    tick(1);
    put0(8'h07);
    tick(12);
    e = '{8'h30, 8'h37, 8'h20};
    chk_seq("t6", q0, e);
    check("t6 busy", busy0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hex_uart_dumper.md
Name: hex_uart_dumper

Overview:
- Parametrised successor to the single-byte PS/2 scan-code monitor formatter.
- Accepts data words of DATA_BYTES bytes and buffers them in an internal FIFO.
- Streams each word to a UART transmitter as ASCII hex digits, MSB nibble first, followed by a separator character.
- Optional CR/LF line wrap every WORDS_PER_LINE words; honours UART tx_full backpressure. Sits between any byte/word producer (PS/2 receiver, bus snooper) and the uart block's write port.

Parameters:
DATA_BYTES, 1, bytes per input word (1..4); emits 2*DATA_BYTES hex chars per word
FIFO_W, 2, FIFO address width; depth = 2**FIFO_W words
WORDS_PER_LINE, 8, words per line before CR/LF replaces separator; 0 = never wrap
SEP_CHAR, 8'h20, separator emitted after each word (ASCII space)
UPPER_CASE, 1, 1: hex A-F -> 8'h41-8'h46; 0: -> 8'h61-8'h66

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
din  input  8*DATA_BYTES  word to dump
din_valid  input  1  write strobe, sampled at rising clk
din_full  output  1  FIFO full; registered, derived from FIFO count
overflow_tick  output  1  one-cycle pulse: din_valid while din_full, word dropped
tx_full  input  1  UART TX FIFO full (backpressure)
wr_uart  output  1  one-cycle write strobe to UART
w_data  output  8  ASCII char to UART, valid when wr_uart=1
busy  output  1  state!=idle or FIFO non-empty

Behaviour:
- Reset (async, any time): FIFO emptied, state=idle, nibble and word counters=0. Outputs: din_full=0, overflow_tick=0, wr_uart=0, busy=0, w_data=SEP_CHAR. A partially emitted word or line is abandoned; no CR/LF is emitted.
- FIFO write: on an edge with din_valid=1 and din_full=0.
  - din_valid=1 with din_full=1: word dropped, overflow_tick=1 next cycle.
  - din_full reflects the count before the edge. A write is rejected when full even if a pop occurs in the same cycle.
  - Push and pop in the same cycle is legal when not full; count is unchanged.
- FSM states: idle, digit, sep, cr, lf.
  - idle: if FIFO non-empty, pop the head into data_reg, nibble_cnt=2*DATA_BYTES-1, go to digit. The pop is independent of tx_full.
  - digit: w_data = ascii(data_reg nibble[nibble_cnt]), where nibble 0 = bits 3:0.
    - If tx_full=0: wr_uart=1; if nibble_cnt=0 go to sep, else decrement nibble_cnt.
    - If tx_full=1: wr_uart=0 and hold.
  - sep: if WORDS_PER_LINE!=0 and word_cnt=WORDS_PER_LINE-1, go to cr with word_cnt=0; no output this cycle.
    - Otherwise w_data=SEP_CHAR; when tx_full=0, wr_uart=1, increment word_cnt (wraps per its width) and go to idle.
  - cr: w_data=8'h0D; when tx_full=0, wr_uart=1, go to lf.
  - lf: w_data=8'h0A; when tx_full=0, wr_uart=1, go to idle.
  - In every state, tx_full=1 holds the state and keeps wr_uart=0.
- ASCII map: 0-9 -> 8'h30-8'h39; A-F per UPPER_CASE.
- w_data is combinational from state and data_reg; wr_uart is combinational, high only in emitting states with tx_full=0.
- Latency with FIFO empty and idle: a word written at edge k produces its first wr_uart during the cycle after edge k+2.
- Throughput with tx_full=0: one char per clock, plus one idle cycle per word and one extra cycle at a line wrap.
- No char is ever duplicated or skipped under any tx_full pattern. Words are emitted in write order.
- busy stays high until the final separator or LF strobe has completed.

Test Plan:
1. Defaults; din=8'hF0 single write, tx_full=0 -> wr_uart chars 8'h46,8'h30,8'h20 on consecutive cycles, first 2 cycles after the accepting edge; busy then falls.
2. DATA_BYTES=2, UPPER_CASE=0; din=16'h1A2F -> 8'h31,8'h61,8'h32,8'h66,8'h20.
3. WORDS_PER_LINE=2; bytes 8'h01, 8'h02, 8'h03 -> 30 31 20 30 32 0D 0A 30 33 20.
4. Word 8'hC5, tx_full toggled high for 3 cycles mid-word, and high again before the separator -> exactly 43 35 20 emitted; wr_uart=0 whenever tx_full=1.
5. Defaults; tx_full=1; 6 back-to-back writes 8'h10..8'h15 -> 5 accepted (first popped to data_reg), din_full=1 after the 5th, overflow_tick pulses once on the 6th. Release tx_full -> output 31 30 20 … 31 34 20; 8'h15 is absent.
6. Reset asserted mid-word after the 1st digit of 8'hAB, with 2 words queued -> wr_uart=0, busy=0 and din_full=0 immediately. After release, a new write 8'h07 gives 30 37 20 with word_cnt restarted.
